key_debounce: RTL and testbench

//  Input-side counterpart to the LED output drivers. Takes N raw mechanical

---
 rtl/key_debounce_pkg.sv | 10 +
 rtl/key_debounce_if.sv | 10 +
 rtl/key_debounce_ch.sv | 68 ++++++
 rtl/key_debounce.sv | 41 ++++
 tb/tb_key_debounce.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// key_pkg: debounce FSM state type and millisecond-to-cycle helpers
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  function automatic int ms_to_cyc(int clk_hz, int ms);
    return clk_hz / 1000 * ms;
  endfunction
  function automatic int cnt_width(int cyc);
    return $clog2(cyc + 1);
  endfunction
endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key pins in, debounced level and event pulses out
interface key_debounce_if #(parameter int N = 4);
  logic [N-1:0] key_in;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  modport master (output key_in, input key_level, key_press, key_release, key_long);
  modport slave (input key_in, output key_level, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - synchroniser, debounce FSM, hold counter
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYC     = 1_000_000,
  parameter int LONG_CYC   = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int CW = cnt_width(DB_CYC);
  localparam int HW = cnt_width(LONG_CYC);
  logic [1:0] sync;
  logic s;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic db_done, hold_run, level_n, press_n, release_n, long_n;
  assign s = sync[1];
  assign db_done = cnt == CW'(DB_CYC - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
      st <= IDLE;
      cnt <= '0;
      hold <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_long <= 1'b0;
    end else begin
      sync <= {sync[0], key_in ^ ACTIVE_LOW};
      st <= st_n;
      cnt <= cnt_n;
      hold <= hold_n;
      key_level <= level_n;
      key_press <= press_n;
      key_release <= release_n;
      key_long <= long_n;
    end
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE:         st_n = s ? PRESS_WAIT : IDLE;
      PRESS_WAIT:   st_n = !s ? IDLE : db_done ? PRESSED : PRESS_WAIT;
      PRESSED:      st_n = s ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: st_n = s ? PRESSED : db_done ? IDLE : RELEASE_WAIT;
      default:      st_n = IDLE;
    endcase
  end
  // hold keeps counting through release bounces and saturates at LONG_CYC-1
  always_comb begin
    hold_run = (st == PRESSED || st == RELEASE_WAIT) && st_n != IDLE;
    cnt_n = ((st == PRESS_WAIT || st == RELEASE_WAIT) && st_n == st) ? cnt + 1'b1 : '0;
    hold_n = st_n == IDLE ? '0 : (hold_run && hold != HW'(LONG_CYC - 1)) ? hold + 1'b1 : hold;
    level_n = st_n == PRESSED || st_n == RELEASE_WAIT;
    press_n = st == PRESS_WAIT && st_n == PRESSED;
    release_n = st == RELEASE_WAIT && st_n == IDLE;
    long_n = hold_run && hold == HW'(LONG_CYC - 2);
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: N independent debounced key channels with press/release/long events
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input logic clk,
  input logic rstn,
  key_debounce_if.slave kb
);
  localparam int DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  logic [N_KEYS-1:0] lvl, prs, rel, lng;
  initial begin
    assert (DB_CYC >= 1) else $fatal(1, "key_debounce: DB_CYC must be >= 1");
    assert (LONG_CYC > DB_CYC) else $fatal(1, "key_debounce: LONG_CYC must exceed DB_CYC");
  end
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYC(DB_CYC),
      .LONG_CYC(LONG_CYC),
      .ACTIVE_LOW(ACTIVE_LOW != 0)
    ) u_ch (
      .clk(clk),
      .rstn(rstn),
      .key_in(kb.key_in[i]),
      .key_level(lvl[i]),
      .key_press(prs[i]),
      .key_release(rel[i]),
      .key_long(lng[i])
    );
  end
  assign kb.key_level = lvl;
  assign kb.key_press = prs;
  assign kb.key_release = rel;
  assign kb.key_long = lng;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed vector table plus randomized run against a run-length reference model
module tb_key_debounce;
  localparam int DB = 4;
  localparam int LONG = 20;
  typedef struct {
    logic [3:0] pr;
    int n;
    logic [3:0] lvl, prs, rel, lng;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [3:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_lng;
  int run[4], age[4];
  vec_t tbl[$];
  key_debounce_if #(.N(4)) kb();
  key_debounce #(
    .N_KEYS(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .kb(kb)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0;
    for (int i = 0; i < 4; i++) begin
      run[i] = 0;
      age[i] = 0;
    end
  endtask
  // a level is accepted after DB+1 consecutive synchronised samples disagree with it
  task automatic model_step();
    logic [3:0] p;
    logic s;
    p = ~kb.key_in;
    m_prs = '0; m_rel = '0; m_lng = '0;
    for (int i = 0; i < 4; i++) begin
      s = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = p[i];
      run[i] = (s != m_lvl[i]) ? run[i] + 1 : 0;
      if (run[i] == DB + 1) begin
        m_lvl[i] = s;
        run[i] = 0;
        if (s) begin
          m_prs[i] = 1'b1;
          age[i] = 0;
        end else m_rel[i] = 1'b1;
      end else if (m_lvl[i]) begin
        age[i]++;
        if (age[i] == LONG - 1) m_lng[i] = 1'b1;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    else model_reset();
    @(negedge clk);
    cmp("model_level", kb.key_level, m_lvl);
    cmp("model_press", kb.key_press, m_prs);
    cmp("model_release", kb.key_release, m_rel);
    cmp("model_long", kb.key_long, m_lng);
  endtask
  task automatic add(input logic [3:0] pr, input int n, input logic [3:0] lvl, input logic [3:0] prs,
                     input logic [3:0] rel, input logic [3:0] lng);
    tbl.push_back('{pr, n, lvl, prs, rel, lng});
  endtask
  initial begin
    logic [3:0] pr;
    int dur[4];
    int r;
    kb.key_in = 4'hF;
    model_reset();
    @(negedge clk);
    cmp("reset_level", kb.key_level, 4'h0);
    cmp("reset_press", kb.key_press, 4'h0);
    cmp("reset_release", kb.key_release, 4'h0);
    cmp("reset_long", kb.key_long, 4'h0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();
    // clean press held 10 cycles then release
    add(4'h1, 6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 3, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 6, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    // bouncing key1 then settling pressed
    for (int k = 0; k < 3; k++) begin
      add(4'h2, 2, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    add(4'h2, 6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h0, 4'h0);
    add(4'h0, 6, 4'h2, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h2, 4'h0);
    // key2 long hold
    add(4'h4, 6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h4, 1, 4'h4, 4'h4, 4'h0, 4'h0);
    add(4'h4, 18, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h4, 1, 4'h4, 4'h0, 4'h0, 4'h4);
    add(4'h4, 4, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 6, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    // held key with a 2-cycle release glitch
    add(4'h1, 7, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 2, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 2, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 6, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 6, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    // all keys on the same edge
    add(4'hF, 6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0);
    add(4'hF, 1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(4'h0, 6, 4'hF, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'hF, 4'h0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    foreach (tbl[k]) begin
      kb.key_in = ~tbl[k].pr;
      repeat (tbl[k].n) tick();
      cmp($sformatf("vec%0d_level", k), kb.key_level, tbl[k].lvl);
      cmp($sformatf("vec%0d_press", k), kb.key_press, tbl[k].prs);
      cmp($sformatf("vec%0d_release", k), kb.key_release, tbl[k].rel);
      cmp($sformatf("vec%0d_long", k), kb.key_long, tbl[k].lng);
    end
    // reset while key3 is held
    kb.key_in = ~4'h8;
    repeat (7) tick();
    cmp("rst_pre_press", kb.key_press, 4'h8);
    repeat (3) tick();
    cmp("rst_pre_level", kb.key_level, 4'h8);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    cmp("rst_async_level", kb.key_level, 4'h0);
    cmp("rst_async_press", kb.key_press, 4'h0);
    cmp("rst_async_release", kb.key_release, 4'h0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (6) tick();
    cmp("rst_post_early", kb.key_press, 4'h0);
    tick();
    cmp("rst_post_press", kb.key_press, 4'h8);
    cmp("rst_post_level", kb.key_level, 4'h8);
    kb.key_in = 4'hF;
    repeat (8) tick();
    // randomized bouncy stimulus with a mid-run reset
    pr = 4'h0;
    for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (dur[i] == 0) begin
          pr[i] = ~pr[i];
          r = $urandom_range(0, 9);
          dur[i] = r < 5 ? $urandom_range(1, 3) : r < 9 ? $urandom_range(5, 14) : $urandom_range(18, 40);
        end
        dur[i]--;
      end
      kb.key_in = ~pr;
      if (c == 1500) begin
        rstn = 1'b0;
        model_reset();
        repeat (2) tick();
        rstn = 1'b1;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
